irq_ctrl: RTL and testbench

//  Interrupt controller between the external irq_i lines and the riscv core's single request path.
//  - Synchronises and latches NUM_IRQ sources; each source is level or rising-edge, per-line enable.
//  - Picks the lowest-index pending+enabled line (fixed priority) and runs a req/ack/eoi handshake with the core.
//  - A simple register port lets the core configure it.

---
 rtl/irq_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_irq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
`timescale 1ns/1ps
// irq_ctrl: interrupt controller between the raw irq_i lines and the core's
// single request path. Synchronises each line, latches it as level or
// rising-edge pending, picks the lowest-index pending+enabled line and runs a
// req/ack/eoi handshake with the core. A small register port configures it.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   irq_i            raw interrupt lines (asynchronous to clk)
//   cfg_we_i         register write strobe (single cycle)
//   cfg_addr_i       0 ENABLE, 1 EDGE, 2 PENDING (write-1-clear), 3 STATUS
//   cfg_wdata_i      write data
//   cfg_rdata_o      read data, combinational from cfg_addr_i
//   core_irq_req_o   registered request to the core
//   core_irq_id_o    registered id of the requested / in-service line
//   core_irq_ack_i   core accepts the request (honoured only in REQ)
//   core_irq_eoi_i   core finished the handler (honoured only in SERVICE)
module irq_ctrl #(
    parameter int unsigned NUM_IRQ     = 32,
    parameter int unsigned ID_W        = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               cfg_we_i,
    input  logic [1:0]         cfg_addr_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic [31:0]        cfg_rdata_o,
    output logic               core_irq_req_o,
    output logic [ID_W-1:0]    core_irq_id_o,
    input  logic               core_irq_ack_i,
    input  logic               core_irq_eoi_i
);

    localparam int unsigned DATA_W       = 32;
    localparam logic [1:0]  ADDR_ENABLE  = 2'd0;
    localparam logic [1:0]  ADDR_EDGE    = 2'd1;
    localparam logic [1:0]  ADDR_PENDING = 2'd2;
    localparam logic [1:0]  ADDR_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Synchroniser chain plus one extra stage for rising-edge detection
    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync_d_q;
    logic [NUM_IRQ-1:0] sync_s;
    logic [NUM_IRQ-1:0] rise;

    // Configuration and pending state
    logic [NUM_IRQ-1:0] enable_q;
    logic [NUM_IRQ-1:0] edge_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] sw_clr;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] cand;
    logic [ID_W-1:0]    win_id;

    // FSM and registered outputs
    state_t             state_q;
    state_t             state_d;
    logic               req_q;
    logic               req_d;
    logic [ID_W-1:0]    cur_id_q;
    logic [ID_W-1:0]    cur_id_d;
    logic               ack_take;

    logic               wr_enable;
    logic               wr_edge;
    logic               wr_pending;

    assign wr_enable  = cfg_we_i && (cfg_addr_i == ADDR_ENABLE);
    assign wr_edge    = cfg_we_i && (cfg_addr_i == ADDR_EDGE);
    assign wr_pending = cfg_we_i && (cfg_addr_i == ADDR_PENDING);

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise   = sync_s & ~sync_d_q;

    // Input synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            sync_d_q <= '0;
        end else begin
            sync_q[0] <= irq_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sync_d_q <= sync_s;
        end
    end

    // ENABLE / EDGE registers; bits beyond NUM_IRQ are simply not stored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= '0;
            edge_q   <= '0;
        end else begin
            if (wr_enable) begin
                enable_q <= cfg_wdata_i[NUM_IRQ-1:0];
            end
            if (wr_edge) begin
                edge_q <= cfg_wdata_i[NUM_IRQ-1:0];
            end
        end
    end

    // Clear sources for edge-mode pending bits
    assign ack_take = (state_q == ST_REQ) && core_irq_ack_i;

    always_comb begin
        sw_clr  = '0;
        ack_clr = '0;
        if (wr_pending) begin
            sw_clr = cfg_wdata_i[NUM_IRQ-1:0];
        end
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            ack_clr[i] = ack_take && (cur_id_q == ID_W'(i));
        end
    end

    // Level lines track the synchronised input; edge lines latch with set priority
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (!edge_q[i]) begin
                pending_d[i] = sync_s[i];
            end else if (rise[i]) begin
                pending_d[i] = 1'b1;
            end else if (sw_clr[i] || ack_clr[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Fixed priority: lowest set index of the candidate vector wins
    assign cand = pending_q & enable_q;

    always_comb begin
        win_id = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            cur_id_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            cur_id_q <= cur_id_d;
        end
    end

    // Next-state logic; req is decoded from the next state so it is flop-driven
    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        req_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|cand) begin
                    state_d  = ST_REQ;
                    cur_id_d = win_id;
                end
            end
            ST_REQ: begin
                // Ack beats withdrawal; a higher-priority arrival never preempts cur_id
                if (core_irq_ack_i) begin
                    state_d = ST_SERVICE;
                end else if (!cand[cur_id_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (core_irq_eoi_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d = (state_d == ST_REQ);
    end

    assign core_irq_req_o = req_q;
    assign core_irq_id_o  = cur_id_q;

    // Register read mux
    always_comb begin
        cfg_rdata_o = '0;
        case (cfg_addr_i)
            ADDR_ENABLE:  cfg_rdata_o = DATA_W'(enable_q);
            ADDR_EDGE:    cfg_rdata_o = DATA_W'(edge_q);
            ADDR_PENDING: cfg_rdata_o = DATA_W'(pending_q);
            ADDR_STATUS: begin
                cfg_rdata_o[31]       = (state_q == ST_SERVICE);
                cfg_rdata_o[30]       = req_q;
                cfg_rdata_o[ID_W-1:0] = cur_id_q;
            end
            default: cfg_rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
`timescale 1ns/1ps
// Directed bench for irq_ctrl: register table, priority table and
// hand-written handshake / edge / reset sequences.
module tb_irq_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] irq_i;
    logic        cfg_we_i;
    logic [1:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [31:0] cfg_rdata_o;
    logic        core_irq_req_o;
    logic [4:0]  core_irq_id_o;
    logic        core_irq_ack_i;
    logic        core_irq_eoi_i;

    int checks;
    int failures;

    irq_ctrl #(
        .NUM_IRQ    (32),
        .ID_W       (5),
        .SYNC_STAGES(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq_i         (irq_i),
        .cfg_we_i      (cfg_we_i),
        .cfg_addr_i    (cfg_addr_i),
        .cfg_wdata_i   (cfg_wdata_i),
        .cfg_rdata_o   (cfg_rdata_o),
        .core_irq_req_o(core_irq_req_o),
        .core_irq_id_o (core_irq_id_o),
        .core_irq_ack_i(core_irq_ack_i),
        .core_irq_eoi_i(core_irq_eoi_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } reg_vec_t;

    typedef struct {
        logic [31:0] en;
        logic [31:0] irq;
        logic        exp_req;
        logic [4:0]  exp_id;
    } prio_vec_t;

    reg_vec_t  reg_vec  [6];
    prio_vec_t prio_vec [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = a;
        cfg_wdata_i = d;
        tick(1);
        cfg_we_i    = 1'b0;
        cfg_wdata_i = '0;
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        cfg_addr_i = a;
        #1;
        check(name, cfg_rdata_o, exp);
    endtask

    task automatic req_check(input string name, input logic exp_req);
        check(name, {31'b0, core_irq_req_o}, {31'b0, exp_req});
    endtask

    task automatic id_check(input string name, input logic [4:0] exp_id);
        check(name, {27'b0, core_irq_id_o}, {27'b0, exp_id});
    endtask

    task automatic pulse_ack();
        core_irq_ack_i = 1'b1;
        tick(1);
        core_irq_ack_i = 1'b0;
    endtask

    task automatic pulse_eoi();
        core_irq_eoi_i = 1'b1;
        tick(1);
        core_irq_eoi_i = 1'b0;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        irq_i          = '0;
        cfg_we_i       = 1'b0;
        cfg_addr_i     = 2'd0;
        cfg_wdata_i    = '0;
        core_irq_ack_i = 1'b0;
        core_irq_eoi_i = 1'b0;

        reg_vec[0] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        reg_vec[1] = '{2'd1, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
        reg_vec[2] = '{2'd0, 32'h0000_0000, 32'h0000_0000};
        reg_vec[3] = '{2'd1, 32'h0000_0000, 32'h0000_0000};
        reg_vec[4] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0000};
        reg_vec[5] = '{2'd2, 32'hFFFF_FFFF, 32'h0000_0000};

        prio_vec[0] = '{32'h0000_0001, 32'h0000_0001, 1'b1, 5'd0};
        prio_vec[1] = '{32'hFFFF_FFFF, 32'h8000_0010, 1'b1, 5'd4};
        prio_vec[2] = '{32'hFFFF_FFEF, 32'h8000_0010, 1'b1, 5'd31};
        prio_vec[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 5'd0};
        prio_vec[4] = '{32'hF0F0_0000, 32'h0FF0_0000, 1'b1, 5'd20};
        prio_vec[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd31};
        prio_vec[6] = '{32'hFFFF_FFFF, 32'h0000_0100, 1'b1, 5'd8};

        // Reset
        tick(3);
        req_check("rst_req", 1'b0);
        id_check("rst_id", 5'd0);
        rd_check("rst_status", 2'd3, 32'h0);
        rst_n = 1'b1;
        tick(1);
        rd_check("rst_enable", 2'd0, 32'h0);
        rd_check("rst_pending", 2'd2, 32'h0);

        // Register table
        for (int i = 0; i < 6; i++) begin
            cfg_write(reg_vec[i].addr, reg_vec[i].wdata);
            rd_check($sformatf("reg_vec%0d", i), reg_vec[i].addr, reg_vec[i].exp_rd);
        end

        // Priority table (all lines level mode)
        for (int i = 0; i < 7; i++) begin
            cfg_write(2'd0, prio_vec[i].en);
            irq_i = prio_vec[i].irq;
            tick(4);
            req_check($sformatf("prio%0d_req", i), prio_vec[i].exp_req);
            if (prio_vec[i].exp_req) begin
                id_check($sformatf("prio%0d_id", i), prio_vec[i].exp_id);
            end
            irq_i = '0;
            tick(4);
            req_check($sformatf("prio%0d_drop", i), 1'b0);
        end

        // Basic handshake with exact latency
        cfg_write(2'd0, 32'h1);
        irq_i = 32'h1;
        tick(3);
        req_check("t1_req_early", 1'b0);
        tick(1);
        req_check("t1_req", 1'b1);
        id_check("t1_id", 5'd0);
        rd_check("t1_status_req", 2'd3, 32'h4000_0000);
        pulse_ack();
        req_check("t1_req_after_ack", 1'b0);
        rd_check("t1_status_svc", 2'd3, 32'h8000_0000);
        irq_i = '0;
        tick(3);
        pulse_eoi();
        rd_check("t1_status_idle", 2'd3, 32'h0);
        tick(2);
        req_check("t1_no_rereq", 1'b0);

        // Simultaneous lines, then the lower-priority one after eoi
        cfg_write(2'd0, 32'hFFFF_FFFF);
        irq_i = 32'h8000_0010;
        tick(4);
        req_check("t2_req", 1'b1);
        id_check("t2_id4", 5'd4);
        pulse_ack();
        irq_i = 32'h8000_0000;
        tick(3);
        pulse_eoi();
        req_check("t2_idle_req", 1'b0);
        tick(1);
        req_check("t2_req31", 1'b1);
        id_check("t2_id31", 5'd31);
        pulse_ack();
        irq_i = '0;
        tick(3);
        pulse_eoi();
        tick(2);
        req_check("t2_quiet", 1'b0);

        // Edge line 3: pulse, ack clears, re-pend during service
        cfg_write(2'd0, 32'h8);
        cfg_write(2'd1, 32'h8);
        irq_i[3] = 1'b1;
        tick(1);
        irq_i[3] = 1'b0;
        tick(2);
        rd_check("t3_pending", 2'd2, 32'h8);
        tick(1);
        req_check("t3_req", 1'b1);
        id_check("t3_id", 5'd3);
        pulse_ack();
        rd_check("t3_pending_ack", 2'd2, 32'h0);
        rd_check("t3_status", 2'd3, 32'h8000_0003);
        irq_i[3] = 1'b1;
        tick(1);
        irq_i[3] = 1'b0;
        tick(2);
        rd_check("t3_pending_svc", 2'd2, 32'h8);
        req_check("t3_no_nest", 1'b0);
        pulse_eoi();
        req_check("t3_eoi_idle", 1'b0);
        tick(1);
        req_check("t3_rereq", 1'b1);
        id_check("t3_rereq_id", 5'd3);
        pulse_ack();
        pulse_eoi();
        tick(2);
        req_check("t3_quiet", 1'b0);

        // Withdrawal: level line 5 dropped, then enable cleared
        cfg_write(2'd0, 32'h20);
        irq_i = 32'h20;
        tick(4);
        req_check("t4_req", 1'b1);
        id_check("t4_id", 5'd5);
        irq_i = '0;
        tick(3);
        req_check("t4_req_held", 1'b1);
        tick(1);
        req_check("t4_withdrawn", 1'b0);
        rd_check("t4_status", 2'd3, 32'h0000_0005);
        irq_i = 32'h20;
        tick(4);
        req_check("t4_req2", 1'b1);
        cfg_write(2'd0, 32'h0);
        tick(1);
        req_check("t4_disable_withdraw", 1'b0);
        rd_check("t4_status2", 2'd3, 32'h0000_0005);
        irq_i = '0;
        tick(3);

        // Edge line 2: software clear, and set beating a same-cycle clear
        cfg_write(2'd1, 32'h4);
        irq_i[2] = 1'b1;
        tick(1);
        irq_i[2] = 1'b0;
        tick(2);
        rd_check("t5_pending", 2'd2, 32'h4);
        cfg_write(2'd2, 32'h4);
        rd_check("t5_sw_clear", 2'd2, 32'h0);
        irq_i[2] = 1'b1;
        tick(1);
        irq_i[2] = 1'b0;
        tick(2);
        rd_check("t5_pending2", 2'd2, 32'h4);
        irq_i[2] = 1'b1;
        tick(2);
        cfg_write(2'd2, 32'h4);
        irq_i[2] = 1'b0;
        rd_check("t5_set_wins", 2'd2, 32'h4);
        tick(2);

        // Reset while in service
        cfg_write(2'd0, 32'h1);
        irq_i = 32'h1;
        tick(4);
        req_check("t6_req", 1'b1);
        pulse_ack();
        rd_check("t6_status_svc", 2'd3, 32'h8000_0000);
        rd_check("t6_pending_svc", 2'd2, 32'h5);
        rst_n = 1'b0;
        #2;
        req_check("t6_rst_req", 1'b0);
        rd_check("t6_rst_status", 2'd3, 32'h0);
        rd_check("t6_rst_pending", 2'd2, 32'h0);
        rd_check("t6_rst_enable", 2'd0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        core_irq_ack_i = 1'b1;
        core_irq_eoi_i = 1'b1;
        tick(3);
        core_irq_ack_i = 1'b0;
        core_irq_eoi_i = 1'b0;
        req_check("t6_spurious_req", 1'b0);
        rd_check("t6_spurious_status", 2'd3, 32'h0);
        rd_check("t6_level_resync", 2'd2, 32'h1);
        irq_i = '0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
